alarm_ctrl: RTL and testbench



---
 rtl/alarm_ctrl.sv | 138 +++++++++++++
 tb/tb_alarm_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Clocked alarm supervisor: away/stay arming, tick-driven exit/entry delays,
// a latched alarm that only disarm clears, and sticky per-zone trip capture.
module alarm_ctrl #(
    parameter int unsigned N_DOORS     = 2,
    parameter int unsigned N_WINDOWS   = 3,
    parameter int unsigned EXIT_DELAY  = 8,
    parameter int unsigned ENTRY_DELAY = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic                           arm,
    input  logic                           stay,
    input  logic                           disarm,
    input  logic [N_DOORS-1:0]             doors,
    input  logic [N_WINDOWS-1:0]           windows,
    output logic                           secure,
    output logic                           alarm,
    output logic                           pending,
    output logic [2:0]                     state,
    output logic [N_DOORS+N_WINDOWS-1:0]   zone_trip
);

    localparam int unsigned NZ      = N_DOORS + N_WINDOWS;
    localparam int unsigned MAX_DLY = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
    localparam int unsigned CW      = $clog2(MAX_DLY + 1);
    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DELAY);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DELAY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    state_t          st_q, st_d;
    logic            mode_q, mode_d;   // 1 = stay, 0 = away
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NZ-1:0]   trip_q, trip_d;
    logic [NZ-1:0]   win_z, all_z;
    logic            win_any, door_any;

    always_comb begin
        win_z    = {{N_DOORS{1'b0}}, windows};
        all_z    = {doors, windows};
        win_any  = |windows;
        door_any = |doors;
    end

    always_comb begin
        st_d   = st_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        trip_d = trip_q;
        if (disarm) begin
            st_d  = S_DISARMED;
            cnt_d = '0;
        end else begin
            case (st_q)
                S_DISARMED: begin
                    if (arm) begin
                        trip_d = '0;
                        mode_d = stay;
                        if (stay) begin
                            st_d = S_ARMED;
                        end else begin
                            st_d  = S_EXIT_DLY;
                            cnt_d = EXIT_LD;
                        end
                    end
                end
                S_EXIT_DLY: begin
                    if (win_any) begin
                        trip_d = trip_q | win_z;
                        st_d   = S_ALARM;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) st_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (win_any || (mode_q && door_any)) begin
                        trip_d = trip_q | all_z;
                        st_d   = S_ALARM;
                    end else if (door_any) begin
                        trip_d = trip_q | all_z;
                        cnt_d  = ENTRY_LD;
                        st_d   = S_ENTRY_DLY;
                    end
                end
                S_ENTRY_DLY: begin
                    trip_d = trip_q | all_z;
                    if (win_any) begin
                        st_d = S_ALARM;
                    end else if (tick) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) st_d = S_ALARM;
                    end
                end
                S_ALARM: begin
                    trip_d = trip_q | all_z;
                end
                default: begin
                    st_d  = S_DISARMED;
                    cnt_d = '0;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_DISARMED;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            trip_q  <= '0;
            secure  <= 1'b0;
            alarm   <= 1'b0;
            pending <= 1'b0;
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            trip_q  <= trip_d;
            secure  <= (st_d == S_ARMED);
            alarm   <= (st_d == S_ALARM);
            pending <= (st_d == S_EXIT_DLY) || (st_d == S_ENTRY_DLY);
        end
    end

    assign state     = st_q;
    assign zone_trip = trip_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scenarios plus randomized stimulus for alarm_ctrl, checked every
// cycle against a tick-counting behavioural model.
module tb_alarm_ctrl;

    localparam int unsigned N_DOORS     = 2;
    localparam int unsigned N_WINDOWS   = 3;
    localparam int unsigned EXIT_DELAY  = 8;
    localparam int unsigned ENTRY_DELAY = 8;
    localparam int unsigned NZ          = N_DOORS + N_WINDOWS;

    localparam int M_DIS = 0, M_EXIT = 1, M_ARM = 2, M_ENTRY = 3, M_ALM = 4;

    logic clk, rst_n, tick, arm, stay, disarm;
    logic [N_DOORS-1:0]   doors;
    logic [N_WINDOWS-1:0] windows;
    logic secure, alarm, pending;
    logic [2:0] state;
    logic [NZ-1:0] zone_trip;

    int checks = 0;
    int passed = 0;
    bit run_cmp = 0;

    alarm_ctrl #(
        .N_DOORS    (N_DOORS),
        .N_WINDOWS  (N_WINDOWS),
        .EXIT_DELAY (EXIT_DELAY),
        .ENTRY_DELAY(ENTRY_DELAY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .arm      (arm),
        .stay     (stay),
        .disarm   (disarm),
        .doors    (doors),
        .windows  (windows),
        .secure   (secure),
        .alarm    (alarm),
        .pending  (pending),
        .state    (state),
        .zone_trip(zone_trip)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: counts ticks seen since a delay started instead of a down-counter.
    int            m_st;
    int            m_ticks;
    bit            m_stay;
    logic [NZ-1:0] m_trip;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_DIS; m_ticks = 0; m_stay = 0; m_trip = '0;
        end else if (disarm) begin
            m_st = M_DIS;
        end else begin
            case (m_st)
                M_DIS: if (arm) begin
                    m_trip = '0; m_stay = stay; m_ticks = 0;
                    m_st = stay ? M_ARM : M_EXIT;
                end
                M_EXIT: begin
                    if (windows != 0) begin
                        m_trip = m_trip | {{N_DOORS{1'b0}}, windows};
                        m_st = M_ALM;
                    end else if (tick) begin
                        m_ticks++;
                        if (m_ticks == EXIT_DELAY) m_st = M_ARM;
                    end
                end
                M_ARM: begin
                    if (windows != 0 || (m_stay && doors != 0)) begin
                        m_trip = m_trip | {doors, windows};
                        m_st = M_ALM;
                    end else if (doors != 0) begin
                        m_trip = m_trip | {doors, windows};
                        m_ticks = 0;
                        m_st = M_ENTRY;
                    end
                end
                M_ENTRY: begin
                    m_trip = m_trip | {doors, windows};
                    if (windows != 0) m_st = M_ALM;
                    else if (tick) begin
                        m_ticks++;
                        if (m_ticks == ENTRY_DELAY) m_st = M_ALM;
                    end
                end
                default: m_trip = m_trip | {doors, windows};
            endcase
        end
    end

    logic [NZ+5:0] exp_v, got_v;
    always @(negedge clk) begin
        if (run_cmp) begin
            exp_v = {3'(m_st), m_st == M_ARM, m_st == M_ALM,
                     (m_st == M_EXIT) || (m_st == M_ENTRY), m_trip};
            got_v = {state, secure, alarm, pending, zone_trip};
            checks++;
            if (got_v === exp_v) passed++;
            else $display("FAIL cycle_cmp t=%0t got={st,sec,alm,pend,trip}=%b required=%b",
                          $time, got_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got === req) passed++;
        else $display("FAIL %s got=%0h required=%0h", name, got, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input int req);
        chk(name, 32'(state), 32'(req));
        chk({name, "_model"}, 32'(m_st), 32'(req));
    endtask

    task automatic arm_away_to_armed();
        arm = 1; stay = 0; step(); arm = 0;
        tick = 1;
        repeat (EXIT_DELAY) step();
        tick = 0;
    endtask

    initial begin
        rst_n = 0; tick = 0; arm = 0; stay = 0; disarm = 0; doors = '0; windows = '0;
        repeat (3) step();
        chk("reset_state", 32'(state), 0);
        chk("reset_flags", {29'd0, secure, alarm, pending}, 0);
        chk("reset_trip", 32'(zone_trip), 0);
        rst_n = 1;
        run_cmp = 1;

        // Stay arm, door trip, disarm keeps trip flags
        arm = 1; stay = 1; step(); arm = 0; stay = 0;
        chk_state("stay_armed", 2);
        chk("stay_secure", 32'(secure), 1);
        doors = 2'b01; step(); doors = '0;
        chk_state("stay_door_alarm", 4);
        chk("stay_alarm_flag", 32'(alarm), 1);
        chk("stay_trip", 32'(zone_trip), 32'b01000);
        disarm = 1; step(); disarm = 0;
        chk_state("disarm_state", 0);
        chk("disarm_alarm", 32'(alarm), 0);
        chk("disarm_trip_held", 32'(zone_trip), 32'b01000);

        // Away exit delay with doors open, tick every 4 cycles
        arm = 1; step(); arm = 0;
        chk_state("exit_start", 1);
        chk("exit_pending", 32'(pending), 1);
        doors = 2'b11;
        for (int i = 0; i < EXIT_DELAY; i++) begin
            repeat (3) step();
            chk_state($sformatf("exit_hold_%0d", i), 1);
            tick = 1; step(); tick = 0;
        end
        chk_state("exit_done", 2);
        chk("exit_no_alarm", 32'(alarm), 0);
        chk("exit_trip_clear", 32'(zone_trip), 0);
        doors = '0;

        // Entry delay then disarm after 5 ticks
        step();
        doors = 2'b10; step(); doors = '0;
        chk_state("entry_start", 3);
        chk("entry_pending", 32'(pending), 1);
        repeat (5) begin tick = 1; step(); tick = 0; step(); end
        chk_state("entry_mid", 3);
        disarm = 1; step(); disarm = 0;
        chk_state("entry_disarmed", 0);
        chk("entry_no_alarm", 32'(alarm), 0);

        // Entry delay expiry
        arm_away_to_armed();
        chk_state("away_armed", 2);
        doors = 2'b10; step(); doors = '0;
        chk_state("entry2_start", 3);
        tick = 1;
        repeat (ENTRY_DELAY - 1) step();
        chk_state("entry2_last", 3);
        step(); tick = 0;
        chk_state("entry2_expired", 4);
        chk("entry2_alarm", 32'(alarm), 1);
        chk("entry2_trip4", 32'(zone_trip[4]), 1);
        disarm = 1; step(); disarm = 0;

        // Window and door in the same cycle: alarm wins
        arm_away_to_armed();
        doors = 2'b01; windows = 3'b100; step(); doors = '0; windows = '0;
        chk_state("both_alarm", 4);
        chk("both_trip", 32'(zone_trip), 32'b01100);
        arm = 1; step(); arm = 0;
        chk_state("alarm_ignores_arm", 4);

        // Asynchronous reset mid-cycle, then arm+disarm together
        #1 rst_n = 0;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_flags", {29'd0, secure, alarm, pending}, 0);
        chk("async_rst_trip", 32'(zone_trip), 0);
        #4 rst_n = 1;
        step();
        arm = 1; disarm = 1; step(); arm = 0; disarm = 0;
        chk_state("arm_disarm_together", 0);

        // Randomized stimulus
        for (int c = 0; c < 4000; c++) begin
            arm     = ($urandom_range(0, 9) == 0);
            stay    = $urandom_range(0, 1) == 1;
            disarm  = ($urandom_range(0, 59) == 0);
            tick    = ($urandom_range(0, 2) == 0);
            doors   = ($urandom_range(0, 11) == 0) ? N_DOORS'($urandom) : '0;
            windows = ($urandom_range(0, 39) == 0) ? N_WINDOWS'($urandom) : '0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 0;
                #4 rst_n = 1;
            end
            step();
        end
        arm = 0; disarm = 0; tick = 0; doors = '0; windows = '0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
